// File: rtl/qcw_pkg.sv
// qcw_pkg: shared state encoding and default widths for the QCW phase ramp generator
package qcw_pkg;
  localparam int PHASE_W_DEF = 8;
  localparam int STEP_CYC_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
endpackage

// File: rtl/qcw_edge_det.sv
// qcw_edge_det: single-flop rising-edge detector
module qcw_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  // The flop records "input was seen low", so a level already high out of reset is not an edge
  logic armed;
  always_ff @(posedge clk) armed <= reset ? 1'b0 : ~sig;
  assign rise = sig & armed;
endmodule

// File: rtl/qcw_ramp_gen.sv
// qcw_ramp_gen: steps the QCW driver phase shift from start to end, one step per N resonant cycles
module qcw_ramp_gen
  import qcw_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int STEP_CYC_W = STEP_CYC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  qcw_start,
  input  logic                  qcw_done,
  input  logic                  qcw_halt,
  input  logic                  cycle_finished,
  input  logic [PHASE_W-1:0]    cfg_phase_start,
  input  logic [PHASE_W-1:0]    cfg_phase_end,
  input  logic [PHASE_W-1:0]    cfg_step,
  input  logic [STEP_CYC_W-1:0] cfg_cycles_per_step,
  output logic [PHASE_W-1:0]    phase_shift,
  output logic                  ramp_active,
  output logic                  ramp_done
);
  state_t state;
  logic start_rise, cyc_rise, up;
  logic [PHASE_W-1:0] sh_end, sh_step, nxt;
  logic [STEP_CYC_W-1:0] sh_cps, cnt, last;
  logic [PHASE_W:0] sum, diff;
  qcw_edge_det u_start (.clk(clk), .reset(reset), .sig(qcw_start), .rise(start_rise));
  qcw_edge_det u_cyc (.clk(clk), .reset(reset), .sig(cycle_finished), .rise(cyc_rise));
  // Extra bit catches overflow going up and borrow going down, both clamp to end
  always_comb begin
    up = sh_end > phase_shift;
    sum = {1'b0, phase_shift} + {1'b0, sh_step};
    diff = {1'b0, phase_shift} - {1'b0, sh_step};
    nxt = (sh_step == '0) ? sh_end :
          up ? ((sum >= {1'b0, sh_end}) ? sh_end : sum[PHASE_W-1:0]) :
               ((diff[PHASE_W] || diff <= {1'b0, sh_end}) ? sh_end : diff[PHASE_W-1:0]);
    last = (sh_cps == '0) ? '0 : sh_cps - STEP_CYC_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase_shift <= '0;
      ramp_active <= 1'b0;
      ramp_done <= 1'b0;
      cnt <= '0;
      sh_end <= '0;
      sh_step <= '0;
      sh_cps <= '0;
    end else if (qcw_done || qcw_halt) begin
      state <= IDLE;
      phase_shift <= '0;
      ramp_active <= 1'b0;
      ramp_done <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_rise) begin
          sh_end <= cfg_phase_end;
          sh_step <= cfg_step;
          sh_cps <= cfg_cycles_per_step;
          phase_shift <= cfg_phase_start;
          cnt <= '0;
          state <= (cfg_phase_start == cfg_phase_end) ? HOLD : RAMP;
          ramp_active <= 1'b1;
          ramp_done <= cfg_phase_start == cfg_phase_end;
        end
        RAMP: if (cyc_rise) begin
          if (cnt >= last) begin
            cnt <= '0;
            phase_shift <= nxt;
            if (nxt == sh_end) begin
              state <= HOLD;
              ramp_done <= 1'b1;
            end
          end else cnt <= cnt + STEP_CYC_W'(1);
        end
        HOLD: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qcw_ramp_gen.sv
// tb_qcw_ramp_gen: scoreboard bench; stimulus pushes expected output changes, a monitor pops and checks them
module tb_qcw_ramp_gen;
  logic clk = 0, reset = 1, qcw_start = 0, qcw_done = 0, qcw_halt = 0, cycle_finished = 0;
  logic [7:0] cfg_phase_start = 0, cfg_phase_end = 0, cfg_step = 0;
  logic [15:0] cfg_cycles_per_step = 0;
  logic [7:0] phase_shift;
  logic ramp_active, ramp_done;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [7:0] ph; logic act; logic dn; int at;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [9:0] last_o;
  logic [7:0] up_tab [5] = '{18, 26, 34, 42, 50};
  logic [7:0] dn_tab [4] = '{136, 72, 8, 5};
  logic [7:0] sh_tab [4] = '{26, 34, 42, 50};

  qcw_ramp_gen dut (
    .clk(clk), .reset(reset), .qcw_start(qcw_start), .qcw_done(qcw_done), .qcw_halt(qcw_halt),
    .cycle_finished(cycle_finished), .cfg_phase_start(cfg_phase_start), .cfg_phase_end(cfg_phase_end),
    .cfg_step(cfg_step), .cfg_cycles_per_step(cfg_cycles_per_step),
    .phase_shift(phase_shift), .ramp_active(ramp_active), .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) last_o = {phase_shift, ramp_active, ramp_done};
    else if ({phase_shift, ramp_active, ramp_done} !== last_o) begin
      last_o = {phase_shift, ramp_active, ramp_done};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got phase=%0d active=%0b done=%0b at cycle %0d, expected no change",
                 phase_shift, ramp_active, ramp_done, cyc);
      end else begin
        e = q.pop_front();
        if (phase_shift !== e.ph || ramp_active !== e.act || ramp_done !== e.dn || cyc != e.at) begin
          errors++;
          $display("FAIL output_change: got phase=%0d active=%0b done=%0b cycle=%0d, expected phase=%0d active=%0b done=%0b cycle=%0d",
                   phase_shift, ramp_active, ramp_done, cyc, e.ph, e.act, e.dn, e.at);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_o(logic [7:0] ph, logic act, logic dn);
    q.push_back('{ph, act, dn, cyc + 1});
  endtask

  task automatic start(logic [7:0] ps, logic [7:0] pe, logic [7:0] st, logic [15:0] cps, bit keep);
    cfg_phase_start = ps;
    cfg_phase_end = pe;
    cfg_step = st;
    cfg_cycles_per_step = cps;
    qcw_start = 1;
    tick();
    if (!keep) qcw_start = 0;
  endtask

  task automatic pulse();
    cycle_finished = 1;
    tick();
    cycle_finished = 0;
    tick();
  endtask

  task automatic drain(string name);
    tick(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected output changes never appeared, expected 0 pending", name, q.size());
      q.delete();
    end
  endtask

  task automatic stop_ramp(string name);
    expect_o(0, 0, 0);
    qcw_done = 1;
    tick();
    qcw_done = 0;
    tick();
    drain(name);
  endtask

  task automatic check_idle(string name);
    checks++;
    if (phase_shift !== 0 || ramp_active !== 0 || ramp_done !== 0) begin
      errors++;
      $display("FAIL %s: got phase=%0d active=%0b done=%0b, expected phase=0 active=0 done=0",
               name, phase_shift, ramp_active, ramp_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check_idle("reset_state");
    reset = 0;
    tick(2);
    // up ramp, two cycles per step
    expect_o(10, 1, 0);
    start(10, 50, 8, 2, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k % 2 == 0 && k <= 10) expect_o(up_tab[k/2-1], 1, k == 10);
      pulse();
    end
    drain("up_ramp");
    stop_ramp("up_stop");
    // downward ramp clamps at end without wrapping
    expect_o(200, 1, 0);
    start(200, 5, 64, 1, 0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_o(dn_tab[k], 1, k == 3);
      pulse();
    end
    drain("down_clamp");
    stop_ramp("down_stop");
    // halt coincident with a cycle edge wins
    expect_o(10, 1, 0);
    start(10, 50, 8, 1, 0);
    expect_o(18, 1, 0);
    pulse();
    cycle_finished = 1;
    qcw_halt = 1;
    expect_o(0, 0, 0);
    tick();
    cycle_finished = 0;
    qcw_halt = 0;
    tick();
    pulse();
    pulse();
    drain("halt_mid_ramp");
    // zero step jumps to end
    expect_o(20, 1, 0);
    start(20, 90, 0, 1, 0);
    expect_o(90, 1, 1);
    pulse();
    pulse();
    drain("step_zero");
    stop_ramp("step_zero_stop");
    // zero cycles-per-step acts as one
    expect_o(10, 1, 0);
    start(10, 50, 8, 0, 0);
    expect_o(18, 1, 0);
    pulse();
    expect_o(26, 1, 0);
    pulse();
    drain("cps_zero");
    stop_ramp("cps_zero_stop");
    // start equals end goes straight to hold
    expect_o(33, 1, 1);
    start(33, 33, 4, 1, 0);
    pulse();
    drain("start_eq_end");
    stop_ramp("start_eq_end_stop");
    // config changes and a second start during the ramp are ignored
    expect_o(10, 1, 0);
    start(10, 50, 8, 1, 0);
    expect_o(18, 1, 0);
    pulse();
    cfg_phase_end = 20;
    cfg_step = 1;
    qcw_start = 1;
    tick();
    qcw_start = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_o(sh_tab[k], 1, k == 3);
      pulse();
    end
    drain("shadowing");
    stop_ramp("shadowing_stop");
    // start edge while done high, and start edge coincident with halt, are dropped
    cfg_phase_start = 10;
    cfg_phase_end = 50;
    qcw_done = 1;
    qcw_start = 1;
    tick(2);
    qcw_done = 0;
    tick(2);
    qcw_start = 0;
    tick();
    drain("start_during_done");
    qcw_halt = 1;
    qcw_start = 1;
    tick();
    qcw_halt = 0;
    tick(2);
    qcw_start = 0;
    tick();
    drain("start_with_halt");
    // reset mid-ramp with start held high
    expect_o(10, 1, 0);
    start(10, 50, 8, 1, 1);
    expect_o(18, 1, 0);
    pulse();
    drain("pre_reset_ramp");
    cycle_finished = 1;
    reset = 1;
    tick();
    cycle_finished = 0;
    tick();
    reset = 0;
    check_idle("reset_mid_ramp");
    pulse();
    pulse();
    drain("no_ramp_after_reset");
    check_idle("idle_after_reset");
    qcw_start = 0;
    tick();
    expect_o(10, 1, 0);
    qcw_start = 1;
    tick();
    qcw_start = 0;
    expect_o(18, 1, 0);
    pulse();
    drain("restart_after_reset");
    stop_ramp("restart_stop");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
